// File: rtl/dnn_layer_seq.sv
// dnn_layer_seq: sequential dense layer, one input feature per cycle across all neurons in parallel
module dnn_layer_seq #(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 4,
  parameter int DW      = 5,
  parameter int ACC_W   = 17,
  parameter int RELU_EN = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*DW-1:0]          x_flat,
  input  logic [N_IN*N_OUT*DW-1:0]    w_flat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_OUT*ACC_W-1:0]      y_flat,
  output logic                        busy
);
  localparam int AW = 2*DW + $clog2(N_IN) + 1;
  localparam int SW = (AW > ACC_W ? AW : ACC_W) + 1;
  localparam int KW = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam logic signed [SW-1:0] Y_MAX = (SW'(1) <<< (ACC_W-1)) - SW'(1);
  localparam logic signed [SW-1:0] Y_MIN = -Y_MAX - SW'(1);
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  state_t                      state;
  logic [KW-1:0]               k;
  logic [N_IN*DW-1:0]          x_r;
  logic [N_IN*N_OUT*DW-1:0]    w_r;
  logic signed [AW-1:0]        acc [N_OUT];
  logic signed [AW-1:0]        sum [N_OUT];
  logic signed [ACC_W-1:0]     y_next [N_OUT];
  logic signed [DW-1:0]        xk;
  logic                        accept;
  logic                        last;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = k == KW'(N_IN-1);
  assign xk       = x_r[int'(k)*DW +: DW];
  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    logic signed [DW-1:0] wk;
    logic signed [SW-1:0] sx;
    logic signed [SW-1:0] sat;
    assign wk        = w_r[(int'(k)*N_OUT + j)*DW +: DW];
    assign sum[j]    = acc[j] + AW'(xk) * AW'(wk);
    assign sx        = SW'(sum[j]);
    assign sat       = sx > Y_MAX ? Y_MAX : sx < Y_MIN ? Y_MIN : sx;
    assign y_next[j] = (RELU_EN != 0 && sat[SW-1]) ? '0 : ACC_W'(sat);
  end
  // control FSM, operand capture, accumulation and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y_flat    <= '0;
      x_r       <= '0;
      w_r       <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else if (accept) begin
      state     <= MAC;
      k         <= '0;
      busy      <= 1'b1;
      out_valid <= 1'b0;
      x_r       <= x_flat;
      w_r       <= w_flat;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else if (state == MAC) begin
      for (int j = 0; j < N_OUT; j++) acc[j] <= sum[j];
      k <= k + KW'(1);
      if (last) begin
        state     <= DONE;
        busy      <= 1'b0;
        out_valid <= 1'b1;
        k         <= '0;
        for (int j = 0; j < N_OUT; j++) y_flat[j*ACC_W +: ACC_W] <= y_next[j];
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dnn_layer_seq.sv
// tb_dnn_layer_seq: directed checks of the sequential dense layer across four parameterisations
module tb_dnn_layer_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [19:0] x_flat = '0;
  logic [79:0] w_flat = '0;
  logic [4:0]  x3 = '0;
  logic [9:0]  w3 = '0;
  logic in_ready0, in_ready1, in_ready2, in_ready3;
  logic out_valid0, out_valid1, out_valid2, out_valid3;
  logic busy0, busy1, busy2, busy3;
  logic [67:0] y0;
  logic [31:0] y1;
  logic [67:0] y2;
  logic [33:0] y3;
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  dnn_layer_seq u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x_flat(x_flat),
    .w_flat(w_flat), .out_valid(out_valid0), .out_ready(out_ready), .y_flat(y0), .busy(busy0));
  dnn_layer_seq #(.ACC_W(8)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .x_flat(x_flat),
    .w_flat(w_flat), .out_valid(out_valid1), .out_ready(out_ready), .y_flat(y1), .busy(busy1));
  dnn_layer_seq #(.RELU_EN(1)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x_flat(x_flat),
    .w_flat(w_flat), .out_valid(out_valid2), .out_ready(out_ready), .y_flat(y2), .busy(busy2));
  dnn_layer_seq #(.N_IN(1), .N_OUT(2)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .x_flat(x3),
    .w_flat(w3), .out_valid(out_valid3), .out_ready(out_ready), .y_flat(y3), .busy(busy3));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ops(input int a, input int b, input int c, input int d, input int wv);
    x_flat = {5'(d), 5'(c), 5'(b), 5'(a)};
    for (int i = 0; i < 16; i++) w_flat[i*5 +: 5] = 5'(wv);
  endtask
  task automatic do_accept;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step;
    in_valid  = 1'b0;
  endtask
  task automatic wait0(output int lat, output int bcnt);
    lat  = 0;
    bcnt = int'(busy0);
    while (!out_valid0 && lat < 20) begin
      step;
      lat++;
      bcnt += int'(busy0);
    end
  endtask
  task automatic test_reset;
    step;
    step;
    nvec++; if (out_valid0 !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid0); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy0); end
    nvec++; if (y0 !== 68'd0) begin nerr++; $display("FAIL reset_y: got %h want 0", y0); end
    rst = 1'b0;
    #1;
    nvec++; if (in_ready0 !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready0); end
  endtask
  task automatic test_basic;
    int lat, bcnt;
    set_ops(1, 2, 3, 4, 1);
    do_accept;
    nvec++; if (busy0 !== 1'b1 || out_valid0 !== 1'b0) begin nerr++; $display("FAIL basic_after_accept: got busy=%b ov=%b want busy=1 ov=0", busy0, out_valid0); end
    wait0(lat, bcnt);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL basic_latency: got %0d want 4", lat); end
    nvec++; if (bcnt !== 4) begin nerr++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
    nvec++; if (y0 !== {4{17'd10}}) begin nerr++; $display("FAIL basic_y: got %h want %h", y0, {4{17'd10}}); end
    nvec++; if (busy0 !== 1'b0) begin nerr++; $display("FAIL basic_busy_done: got %b want 0", busy0); end
  endtask
  task automatic test_saturate;
    int lat, bcnt;
    set_ops(-16, -16, -16, -16, -16);
    do_accept;
    wait0(lat, bcnt);
    nvec++; if (y0 !== {4{17'd1024}}) begin nerr++; $display("FAIL sat_wide_y: got %h want %h", y0, {4{17'd1024}}); end
    nvec++; if (out_valid1 !== 1'b1 || y1 !== {4{8'd127}}) begin nerr++; $display("FAIL sat_narrow_y: got ov=%b y=%h want ov=1 y=%h", out_valid1, y1, {4{8'd127}}); end
  endtask
  task automatic test_relu;
    int lat, bcnt;
    set_ops(1, 0, 0, 0, 0);
    w_flat[0 +: 5]  = 5'h1D;
    w_flat[5 +: 5]  = 5'd5;
    w_flat[10 +: 5] = 5'd0;
    w_flat[15 +: 5] = 5'h1F;
    do_accept;
    wait0(lat, bcnt);
    nvec++; if (y2 !== {17'd0, 17'd0, 17'd5, 17'd0}) begin nerr++; $display("FAIL relu_on_y: got %h want %h", y2, {17'd0, 17'd0, 17'd5, 17'd0}); end
    nvec++; if (y0 !== {17'h1FFFF, 17'd0, 17'd5, 17'h1FFFD}) begin nerr++; $display("FAIL relu_off_y: got %h want %h", y0, {17'h1FFFF, 17'd0, 17'd5, 17'h1FFFD}); end
  endtask
  task automatic test_back_to_back;
    int lat, bcnt;
    set_ops(1, 2, 3, 4, 1);
    do_accept;
    out_ready = 1'b0;
    wait0(lat, bcnt);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int c = 0; c < 10; c++) begin
      step;
      nvec++;
      if (y0 !== {4{17'd10}} || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
        nerr++; $display("FAIL bp_hold_%0d: got y=%h ir=%b ov=%b want y=%h ir=0 ov=1", c, y0, in_ready0, out_valid0, {4{17'd10}});
      end
    end
    set_ops(2, 2, 2, 2, 3);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    nvec++; if (in_ready0 !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready: got %b want 1", in_ready0); end
    step;
    nvec++; if (out_valid0 !== 1'b0 || busy0 !== 1'b1) begin nerr++; $display("FAIL b2b_accept: got ov=%b busy=%b want ov=0 busy=1", out_valid0, busy0); end
    set_ops(0, 0, 0, 0, 0);
    step;
    step;
    in_valid = 1'b0;
    wait0(lat, bcnt);
    nvec++; if (lat !== 2) begin nerr++; $display("FAIL b2b_latency: got %0d more edges want 2", lat); end
    nvec++; if (y0 !== {4{17'd24}}) begin nerr++; $display("FAIL b2b_y: got %h want %h", y0, {4{17'd24}}); end
  endtask
  task automatic test_reset_mid;
    int lat, bcnt;
    set_ops(5, 5, 5, 5, 5);
    do_accept;
    step;
    step;
    #2;
    rst = 1'b1;
    #1;
    nvec++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || y0 !== 68'd0) begin nerr++; $display("FAIL abort: got ov=%b busy=%b y=%h want 0 0 0", out_valid0, busy0, y0); end
    step;
    rst = 1'b0;
    set_ops(1, 1, 1, 1, 2);
    do_accept;
    wait0(lat, bcnt);
    nvec++; if (lat !== 4) begin nerr++; $display("FAIL after_abort_latency: got %0d want 4", lat); end
    nvec++; if (y0 !== {4{17'd8}}) begin nerr++; $display("FAIL after_abort_y: got %h want %h", y0, {4{17'd8}}); end
  endtask
  task automatic test_single_input;
    x3 = 5'd7;
    w3 = {5'h1E, 5'd3};
    set_ops(0, 0, 0, 0, 0);
    do_accept;
    nvec++; if (out_valid3 !== 1'b0 || busy3 !== 1'b1) begin nerr++; $display("FAIL n1_accept: got ov=%b busy=%b want ov=0 busy=1", out_valid3, busy3); end
    step;
    nvec++; if (out_valid3 !== 1'b1) begin nerr++; $display("FAIL n1_latency: got ov=%b want 1", out_valid3); end
    nvec++; if (y3 !== {17'h1FFF2, 17'd21}) begin nerr++; $display("FAIL n1_y: got %h want %h", y3, {17'h1FFF2, 17'd21}); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_saturate;
    test_relu;
    test_back_to_back;
    test_reset_mid;
    test_single_input;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
